// File: rtl/pic_pkg.sv
// Shared constants and priority helpers for the PIC request/priority stage.
// Priority is relative to the lowest-priority pointer lp: rank 0 is the level just above lp.
package pic_pkg;

    localparam int unsigned NUM_IR   = 8;
    localparam int unsigned LVL_W    = 3;
    localparam logic [2:0]  SPUR_LVL = 3'd7;

    typedef struct packed {
        logic       found;
        logic [2:0] lvl;
    } pick_t;

    function automatic logic [2:0] rank(input logic [2:0] lvl, input logic [2:0] lp);
        return lvl - lp - 3'd1;
    endfunction

    function automatic pick_t prio_pick(input logic [7:0] vec, input logic [2:0] lp);
        pick_t      p;
        logic [2:0] idx;
        p = '0;
        // Walk from lowest to highest priority so the highest set bit is written last.
        for (int k = NUM_IR - 1; k >= 0; k--) begin
            idx = lp + 3'd1 + 3'(k);
            if (vec[idx]) begin
                p.found = 1'b1;
                p.lvl   = idx;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/pic_prio_pick.sv
// Combinational rotating priority encoder: finds the highest-priority set bit relative to lp.
module pic_prio_pick
    import pic_pkg::*;
(
    input  logic [7:0] i_vec,
    input  logic [2:0] i_lp,
    output logic       o_found,
    output logic [2:0] o_lvl
);

    pick_t w_pick;

    always_comb begin
        w_pick  = prio_pick(i_vec, i_lp);
        o_found = w_pick.found;
        o_lvl   = w_pick.lvl;
    end

endmodule

// File: rtl/pic_prio_resolver.sv
// 8259-style IRR/ISR holding and priority resolution with fixed or automatic-rotation priority.
// Drives the registered interrupt request and the acknowledged vector level toward CtrlLgc.
module pic_prio_resolver
    import pic_pkg::*;
#(
    parameter int unsigned NUM_IR   = pic_pkg::NUM_IR,
    parameter logic [2:0]  SPUR_LVL = pic_pkg::SPUR_LVL
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_IR-1:0] ir,
    input  logic [NUM_IR-1:0] mask,
    input  logic              ltim,
    input  logic              ar,
    input  logic              inta_first,
    input  logic              eoi,
    input  logic              seoi,
    input  logic [2:0]        seoi_lvl,
    output logic [NUM_IR-1:0] irr,
    output logic [NUM_IR-1:0] isr,
    output logic              int_req,
    output logic              isprior,
    output logic [2:0]        y,
    output logic              spurious
);

    localparam logic [NUM_IR-1:0] ONE = {{(NUM_IR - 1){1'b0}}, 1'b1};

    logic [NUM_IR-1:0] r_irr, r_isr, r_ir_q;
    logic [2:0]        r_lp, r_y;
    logic              r_isprior, r_int_req, r_spurious;

    logic [NUM_IR-1:0] w_cand, w_set, w_clr, w_irr_d, w_isr_d;
    logic [2:0]        w_req_lvl, w_isr_lvl, w_lp_d;
    logic              w_req_found, w_isr_found, w_isprior, w_ack;

    pic_prio_pick u_pick_req (
        .i_vec   (w_cand),
        .i_lp    (r_lp),
        .o_found (w_req_found),
        .o_lvl   (w_req_lvl)
    );

    pic_prio_pick u_pick_isr (
        .i_vec   (r_isr),
        .i_lp    (r_lp),
        .o_found (w_isr_found),
        .o_lvl   (w_isr_lvl)
    );

    always_comb begin
        w_cand    = r_irr & ~mask;
        w_isprior = w_req_found &&
                    (!w_isr_found || (rank(w_req_lvl, r_lp) < rank(w_isr_lvl, r_lp)));
        w_ack     = inta_first && w_isprior;
        w_set     = w_ack ? (ONE << w_req_lvl) : '0;

        // Specific EOI takes precedence over a simultaneous non-specific EOI.
        w_clr  = '0;
        w_lp_d = r_lp;
        if (seoi) begin
            w_clr = ONE << seoi_lvl;
            if (ar) w_lp_d = seoi_lvl;
        end else if (eoi && w_isr_found) begin
            w_clr = ONE << w_isr_lvl;
            if (ar) w_lp_d = w_isr_lvl;
        end

        w_isr_d = (r_isr & ~w_clr) | w_set;

        // Edge mode: a fresh edge re-arms a bit even when it is being acknowledged.
        if (ltim) w_irr_d = ir;
        else      w_irr_d = (r_irr & ir & ~w_set) | (ir & ~r_ir_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_irr      <= '0;
            r_isr      <= '0;
            r_ir_q     <= '1;
            r_lp       <= 3'd7;
            r_y        <= 3'd0;
            r_isprior  <= 1'b0;
            r_int_req  <= 1'b0;
            r_spurious <= 1'b0;
        end else begin
            r_ir_q    <= ir;
            r_irr     <= w_irr_d;
            r_isr     <= w_isr_d;
            r_lp      <= w_lp_d;
            r_isprior <= w_isprior;
            r_int_req <= r_isprior;
            if (inta_first) begin
                r_y        <= w_ack ? w_req_lvl : SPUR_LVL;
                r_spurious <= !w_ack;
            end
        end
    end

    always_comb begin
        irr      = r_irr;
        isr      = r_isr;
        int_req  = r_int_req;
        isprior  = r_isprior;
        y        = r_y;
        spurious = r_spurious;
    end

endmodule

// File: tb/tb_pic_prio_resolver.sv
// Directed self-checking bench for pic_prio_resolver; expected values are hand-computed.
module tb_pic_prio_resolver;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] ir, mask, irr, isr;
    logic       ltim, ar, inta_first, eoi, seoi;
    logic [2:0] seoi_lvl, y;
    logic       int_req, isprior, spurious;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pic_prio_resolver dut (
        .clk        (clk),
        .reset      (reset),
        .ir         (ir),
        .mask       (mask),
        .ltim       (ltim),
        .ar         (ar),
        .inta_first (inta_first),
        .eoi        (eoi),
        .seoi       (seoi),
        .seoi_lvl   (seoi_lvl),
        .irr        (irr),
        .isr        (isr),
        .int_req    (int_req),
        .isprior    (isprior),
        .y          (y),
        .spurious   (spurious)
    );

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_inta();
        inta_first = 1'b1;
        step();
        inta_first = 1'b0;
    endtask

    task automatic pulse_eoi();
        eoi = 1'b1;
        step();
        eoi = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ir = '0; mask = '0; ltim = 1'b0; ar = 1'b0;
        inta_first = 1'b0; eoi = 1'b0; seoi = 1'b0; seoi_lvl = '0;
        step(2);
        chk("rst_irr", irr, 8'h00);
        chk("rst_isr", isr, 8'h00);
        chk("rst_int_req", {7'd0, int_req}, 8'd0);
        chk("rst_isprior", {7'd0, isprior}, 8'd0);
        chk("rst_y", {5'd0, y}, 8'd0);
        chk("rst_spurious", {7'd0, spurious}, 8'd0);
        reset = 1'b0;
        step();

        // Edge mode, two lines rise together.
        ir = 8'h24;
        step();
        chk("edge_irr", irr, 8'h24);
        step();
        chk("edge_intreq_lat2", {7'd0, int_req}, 8'd0);
        step();
        chk("edge_intreq_lat3", {7'd0, int_req}, 8'd1);
        pulse_inta();
        chk("ack_y2", {5'd0, y}, 8'd2);
        chk("ack_isr", isr, 8'h04);
        chk("ack_irr", irr, 8'h20);
        chk("ack_spur", {7'd0, spurious}, 8'd0);
        step();
        chk("drop_isprior", {7'd0, isprior}, 8'd0);
        step();
        chk("drop_intreq", {7'd0, int_req}, 8'd0);

        // IR1 outranks in-service IR2.
        ir = 8'h26;
        step();
        chk("ir1_irr", irr, 8'h22);
        step(2);
        chk("ir1_intreq", {7'd0, int_req}, 8'd1);
        ir = 8'h24;
        step(3);
        chk("ir5_blocked", {7'd0, int_req}, 8'd0);
        chk("ir5_irr", irr, 8'h20);
        pulse_eoi();
        chk("eoi_isr", isr, 8'h00);
        step(2);
        chk("ir5_intreq", {7'd0, int_req}, 8'd1);
        pulse_inta();
        chk("ack_y5", {5'd0, y}, 8'd5);
        chk("ack5_isr", isr, 8'h20);
        ir = 8'h00;
        pulse_eoi();
        step(2);

        // Automatic rotation moves lp to the serviced level.
        ar = 1'b1;
        ir = 8'h08;
        step(3);
        pulse_inta();
        chk("ar_y3", {5'd0, y}, 8'd3);
        ir = 8'h00;
        pulse_eoi();
        chk("ar_eoi_isr", isr, 8'h00);
        ir = 8'h11;
        step(3);
        pulse_inta();
        chk("ar_rot_y4", {5'd0, y}, 8'd4);
        chk("ar_rot_isr", isr, 8'h10);
        ar = 1'b0;
        pulse_eoi();
        chk("ar_eoi2_isr", isr, 8'h00);
        ir = 8'h00;
        step(3);

        // Level-triggered mode.
        ltim = 1'b1;
        ir = 8'h40;
        step(3);
        chk("lvl_intreq", {7'd0, int_req}, 8'd1);
        pulse_inta();
        chk("lvl_y6", {5'd0, y}, 8'd6);
        chk("lvl_irr_held", irr, 8'h40);
        chk("lvl_isr", isr, 8'h40);
        step(2);
        chk("lvl_intreq_drop", {7'd0, int_req}, 8'd0);
        seoi = 1'b1; seoi_lvl = 3'd6;
        step();
        seoi = 1'b0;
        chk("seoi_isr", isr, 8'h00);
        step(2);
        chk("seoi_intreq", {7'd0, int_req}, 8'd1);
        ir = 8'h00;
        step();
        chk("lvl_irr_drop", irr, 8'h00);
        ltim = 1'b0;
        step(3);

        // Request withdrawn before acknowledge.
        ir = 8'h01;
        step();
        chk("spur_irr_set", irr, 8'h01);
        ir = 8'h00;
        step();
        chk("spur_irr_clr", irr, 8'h00);
        pulse_inta();
        chk("spur_y", {5'd0, y}, 8'd7);
        chk("spur_flag", {7'd0, spurious}, 8'd1);
        chk("spur_isr", isr, 8'h00);
        step(3);

        // Build isr = 81, irr = 10 (lp is 3 here), then reset.
        ir = 8'h81;
        step();
        mask = 8'h80;
        pulse_inta();
        chk("pre_y0", {5'd0, y}, 8'd0);
        mask = 8'h00;
        pulse_inta();
        chk("pre_y7", {5'd0, y}, 8'd7);
        chk("pre_spur", {7'd0, spurious}, 8'd0);
        ir = 8'h91;
        step();
        chk("pre_isr", isr, 8'h81);
        chk("pre_irr", irr, 8'h10);
        reset = 1'b1;
        step();
        chk("mid_rst_irr", irr, 8'h00);
        chk("mid_rst_isr", isr, 8'h00);
        chk("mid_rst_int_req", {7'd0, int_req}, 8'd0);
        chk("mid_rst_isprior", {7'd0, isprior}, 8'd0);
        chk("mid_rst_y", {5'd0, y}, 8'd0);
        reset = 1'b0;
        step(2);
        chk("post_rst_no_edge", irr, 8'h00);
        chk("post_rst_intreq", {7'd0, int_req}, 8'd0);
        ir = 8'h00;
        step();
        ir = 8'h81;
        step();
        chk("post_rst_irr", irr, 8'h81);
        pulse_inta();
        chk("post_rst_lp7_y", {5'd0, y}, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
